conf_int_mul__seq__prec_ctrl: RTL and testbench

Multi-cycle, radix-2 shift-add integer multiplier with run-time configurable precision. Only the top `prec` bits of each operand are kept; the lower bits are masked to zero, which trades accuracy for fewer cycles. Supports unsigned and two's-complement operands. Uses a valid/ready handshake on both input and output. It is the registered, handshaked successor to the combinational conf_int_mul blocks in the approximate-arithmetic datapath.

---
 rtl/conf_mul_pkg.sv | 24 ++
 rtl/conf_prec_mask.sv | 18 +
 rtl/conf_int_mul__seq__prec_ctrl.sv | 141 ++++++++++++++
 tb/tb_conf_int_mul__seq__prec_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/conf_mul_pkg.sv
// Shared definitions for the conf_* approximate multiplier family:
// FSM state encoding and the effective-precision rule.
package conf_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // prec==0 selects the default width; anything wider than the datapath is clamped.
  function automatic int unsigned eff_prec(input int unsigned prec,
                                           input int unsigned dpw,
                                           input int unsigned op_bw);
    if (prec == 0) begin
      return op_bw;
    end else if (prec > dpw) begin
      return dpw;
    end else begin
      return prec;
    end
  endfunction

endpackage

// File: rtl/conf_prec_mask.sv
// Keeps the top p_eff bits of an operand and clears the rest.
module conf_prec_mask #(
  parameter int unsigned DPW    = 24,
  parameter int unsigned PREC_W = 5
) (
  input  logic [DPW-1:0]    i_operand,
  input  logic [PREC_W-1:0] i_p_eff,
  output logic [DPW-1:0]    o_masked
);

  always_comb begin
    o_masked = '0;
    for (int i = 0; i < int'(DPW); i++) begin
      o_masked[i] = i_operand[i] & (i >= (int'(DPW) - int'(i_p_eff)));
    end
  end

endmodule

// File: rtl/conf_int_mul__seq__prec_ctrl.sv
// Radix-2 shift-add multiplier with run-time precision: walks only the kept
// multiplier bits, so a narrower precision finishes in fewer cycles.
module conf_int_mul__seq__prec_ctrl
  import conf_mul_pkg::*;
#(
  parameter int unsigned DATA_PATH_BITWIDTH = 24,
  parameter int unsigned OP_BITWIDTH        = 16,
  parameter int unsigned PREC_W             = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0]   a,
  input  logic [DATA_PATH_BITWIDTH-1:0]   b,
  input  logic [PREC_W-1:0]               prec,
  input  logic                            sgn,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [2*DATA_PATH_BITWIDTH-1:0] d,
  output logic                            busy
);

  localparam int unsigned DPW = DATA_PATH_BITWIDTH;
  localparam int unsigned PW  = 2 * DPW;

  state_e            r_state, w_state_nxt;
  logic [PW-1:0]     r_acc, w_acc_nxt, w_acc_step;
  logic [PW-1:0]     r_d, w_d_nxt;
  logic [DPW-1:0]    r_a_m, w_a_nxt;
  logic [DPW-1:0]    r_b_m, w_b_nxt;
  logic [PREC_W-1:0] r_idx, w_idx_nxt;
  logic              r_sgn, w_sgn_nxt;

  logic [PREC_W-1:0] w_p_eff;
  logic [DPW-1:0]    w_a_m, w_b_m;
  logic [PW-1:0]     w_a_ext, w_term;
  logic              w_last;

  always_comb begin
    w_p_eff = PREC_W'(eff_prec(32'(prec), DPW, OP_BITWIDTH));
  end

  conf_prec_mask #(
    .DPW    (DPW),
    .PREC_W (PREC_W)
  ) u_mask_a (
    .i_operand (a),
    .i_p_eff   (w_p_eff),
    .o_masked  (w_a_m)
  );

  conf_prec_mask #(
    .DPW    (DPW),
    .PREC_W (PREC_W)
  ) u_mask_b (
    .i_operand (b),
    .i_p_eff   (w_p_eff),
    .o_masked  (w_b_m)
  );

  // The MSB of a two's-complement multiplier carries weight -2^(DPW-1).
  always_comb begin
    w_a_ext    = r_sgn ? {{DPW{r_a_m[DPW-1]}}, r_a_m} : {{DPW{1'b0}}, r_a_m};
    w_term     = w_a_ext << r_idx;
    w_last     = (r_idx == PREC_W'(DPW - 1));
    w_acc_step = r_acc;
    if (r_b_m[r_idx]) begin
      if (w_last && r_sgn) begin
        w_acc_step = r_acc - w_term;
      end else begin
        w_acc_step = r_acc + w_term;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_d_nxt     = r_d;
    w_a_nxt     = r_a_m;
    w_b_nxt     = r_b_m;
    w_idx_nxt   = r_idx;
    w_sgn_nxt   = r_sgn;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_a_nxt     = w_a_m;
          w_b_nxt     = w_b_m;
          w_sgn_nxt   = sgn;
          w_acc_nxt   = '0;
          w_idx_nxt   = PREC_W'(DPW - 32'(w_p_eff));
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        w_acc_nxt = w_acc_step;
        if (w_last) begin
          w_d_nxt     = w_acc_step;
          w_state_nxt = DONE;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_d     <= '0;
      r_a_m   <= '0;
      r_b_m   <= '0;
      r_idx   <= '0;
      r_sgn   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_d     <= w_d_nxt;
      r_a_m   <= w_a_nxt;
      r_b_m   <= w_b_nxt;
      r_idx   <= w_idx_nxt;
      r_sgn   <= w_sgn_nxt;
    end
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    busy      = (r_state != IDLE);
    d         = r_d;
  end

endmodule

// File: tb/tb_conf_int_mul__seq__prec_ctrl.sv
// Directed bench for the precision-controlled sequential multiplier.
module tb_conf_int_mul__seq__prec_ctrl;

  localparam int unsigned DPW = 24;
  localparam int unsigned PW  = 5;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [DPW-1:0]  a;
  logic [DPW-1:0]  b;
  logic [PW-1:0]   prec;
  logic            sgn;
  logic            out_valid;
  logic            out_ready;
  logic [2*DPW-1:0] d;
  logic            busy;

  int n_pass  = 0;
  int n_total = 0;

  conf_int_mul__seq__prec_ctrl #(
    .DATA_PATH_BITWIDTH (DPW),
    .OP_BITWIDTH        (16),
    .PREC_W             (PW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .prec      (prec),
    .sgn       (sgn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Issue one request; latency counts edges from the accept edge (inclusive)
  // to the first cycle with out_valid high.
  task automatic run_op(input string tag, input logic [23:0] ta, input logic [23:0] tb,
                        input logic [4:0] tp, input logic ts,
                        input logic [47:0] exp_d, input int exp_lat, input bit do_hs);
    int lat;
    a = ta; b = tb; prec = tp; sgn = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = '0; b = '0; prec = '0; sgn = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 48'(lat), 48'(exp_lat));
    chk({tag, "_d"}, d, exp_d);
    if (do_hs) begin
      @(posedge clk); #1;
      chk({tag, "_rdy_back"}, 48'(in_ready), 48'd1);
      chk({tag, "_ov_drop"}, 48'(out_valid), 48'd0);
    end
  endtask

  initial begin
    bit saw_ov;
    rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; prec = '0; sgn = 1'b0; out_ready = 1'b1;
    #2;
    chk("rst_in_ready", 48'(in_ready), 48'd1);
    chk("rst_out_valid", 48'(out_valid), 48'd0);
    chk("rst_busy", 48'(busy), 48'd0);
    chk("rst_d", d, 48'd0);
    #20 rst = 1'b1;
    @(posedge clk); #1;

    run_op("uns_exact", 24'd3, 24'd5, 5'd24, 1'b0, 48'h00000000000F, 25, 1'b1);
    run_op("trunc8", 24'h12ABCD, 24'h030FFF, 5'd8, 1'b0, 48'h003600000000, 9, 1'b1);
    run_op("prec0", 24'h0001FF, 24'h000100, 5'd0, 1'b0, 48'h000000010000, 17, 1'b1);
    run_op("prec31", 24'h0001FF, 24'h000100, 5'd31, 1'b0, 48'h00000001FF00, 25, 1'b1);
    run_op("sgn_neg", 24'hFFFFFD, 24'h000007, 5'd24, 1'b1, 48'hFFFFFFFFFFEB, 25, 1'b1);
    run_op("sgn_min", 24'h800000, 24'h800000, 5'd24, 1'b1, 48'h400000000000, 25, 1'b1);

    // Backpressure: stall in DONE while a new request is offered.
    out_ready = 1'b0;
    run_op("bp", 24'h000010, 24'h000020, 5'd24, 1'b0, 48'h000000000200, 25, 1'b0);
    a = 24'h00000F; b = 24'h00000F; prec = 5'd4; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 48'(out_valid), 48'd1);
      chk("bp_in_ready", 48'(in_ready), 48'd0);
      chk("bp_d", d, 48'h000000000200);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_in_ready", 48'(in_ready), 48'd1);
    chk("bp_rel_out_valid", 48'(out_valid), 48'd0);
    chk("bp_d_held", d, 48'h000000000200);

    // Asynchronous reset in the fifth BUSY cycle.
    a = 24'd3; b = 24'd5; prec = 5'd24; sgn = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_in_ready", 48'(in_ready), 48'd1);
    chk("arst_out_valid", 48'(out_valid), 48'd0);
    chk("arst_busy", 48'(busy), 48'd0);
    chk("arst_d", d, 48'd0);
    #2 rst = 1'b1;
    saw_ov = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) saw_ov = 1'b1;
    end
    chk("arst_no_output", 48'(saw_ov), 48'd0);

    run_op("post_rst", 24'd3, 24'd5, 5'd24, 1'b0, 48'h00000000000F, 25, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
